// File: rtl/lbd_arb_pkg.sv
// ---------------------------------------------------------------------------
// lbd_arb_pkg
// Shared definitions for the two-requester leading-run arbiter:
//   state_t  : output register state (EMPTY / FULL)
//   N_DEF    : default operand width
//   RS_DEF   : default count-width parameter (count output is RS_DEF+1 bits)
//   log2     : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package lbd_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int N_DEF  = 8;
    localparam int RS_DEF = log2(N_DEF);

endpackage

// File: rtl/lead_run_counter.sv
// ---------------------------------------------------------------------------
// lead_run_counter
// Combinational leading-run counter. The result is 1 plus the number of
// consecutive bits, scanning from bit N-2 down to bit 1, that match the sign
// bit N-1. Bit 0 never takes part, so the range is 1..N-1.
// Ports:
//   din  [N-1:0]  operand
//   cnt  [RS:0]   leading-run count
// ---------------------------------------------------------------------------
module lead_run_counter
    import lbd_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RS = log2(N)
) (
    input  logic [N-1:0] din,
    output logic [RS:0]  cnt
);

    logic run;
    logic unused_lsb;

    assign unused_lsb = din[0];

    always_comb begin
        cnt = (RS+1)'(1);
        run = 1'b1;
        for (int i = N - 2; i >= 1; i--) begin
            if (run && (din[i] == din[N-1])) begin
                cnt = cnt + (RS+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lbd_share_arbiter.sv
// ---------------------------------------------------------------------------
// lbd_share_arbiter
// Two requesters share one leading-run counter. A one-entry result register
// (EMPTY/FULL) holds the count and the owning requester id. A new operand is
// accepted whenever the register is empty or being drained this cycle, so
// back-to-back results flow at one per cycle.
// Build option:
//   LBD_ARB_ROUND_ROBIN_EN defined   : ties alternate (pointer moves to the
//                                      requester that lost)
//   LBD_ARB_ROUND_ROBIN_EN undefined : fixed priority, requester 0 wins ties
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid[1:0]       per-requester operand present
//   in_data0, in_data1  operands (N bits)
//   in_ready[1:0]       one-hot accept, combinational
//   out_valid           result register FULL
//   out_ready           consumer takes the result
//   out_shift[RS:0]     leading-run count of the granted operand
//   out_id              requester that owns out_shift
// ---------------------------------------------------------------------------
module lbd_share_arbiter
    import lbd_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RS = log2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   in_valid,
    input  logic [N-1:0] in_data0,
    input  logic [N-1:0] in_data1,
    output logic [1:0]   in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [RS:0]  out_shift,
    output logic         out_id
);

    state_t      state, state_nx;
    logic        ptr;
    logic        acc;
    logic [1:0]  gnt_p0;
    logic        sel_p0;
    logic [N-1:0] data_p0;
    logic [RS:0] cnt_p0;
    logic [RS:0] shift_p1;
    logic        id_p1;

    // Stage 0: arbitration and count on the granted operand
    assign acc = (state == EMPTY) || out_ready;

    always_comb begin
        gnt_p0 = 2'b00;
        if (acc && rst_n) begin
            case (in_valid)
                2'b01:   gnt_p0 = 2'b01;
                2'b10:   gnt_p0 = 2'b10;
                2'b11:   gnt_p0 = ptr ? 2'b10 : 2'b01;
                default: gnt_p0 = 2'b00;
            endcase
        end
    end

    assign sel_p0  = gnt_p0[1];
    assign data_p0 = sel_p0 ? in_data1 : in_data0;

    lead_run_counter #(
        .N  (N),
        .RS (RS)
    ) u_cnt (
        .din (data_p0),
        .cnt (cnt_p0)
    );

`ifdef LBD_ARB_ROUND_ROBIN_EN
    // Pointer names the requester that lost the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt_p0 != 2'b00) begin
            ptr <= ~sel_p0;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        if (gnt_p0 != 2'b00) begin
            state_nx = FULL;
        end else if (out_ready) begin
            state_nx = EMPTY;
        end
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state == FULL);
        in_ready  = gnt_p0;
    end

    // Stage 1: result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_p1 <= '0;
            id_p1    <= 1'b0;
        end else if (gnt_p0 != 2'b00) begin
            shift_p1 <= cnt_p0;
            id_p1    <= sel_p0;
        end
    end

    assign out_shift = shift_p1;
    assign out_id    = id_p1;

endmodule
